// File: rtl/referee_rq_ack.sv
// Round-robin referee between two req/ack clients sharing one req/ack server port.
// Transactions run IDLE -> SERVE -> RESP; a silent server is answered with an all-ones timeout response.
module referee_rq_ack #(
  parameter int REQ_DATA_WIDTH = 8,
  parameter int ACK_DATA_WIDTH = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      client0_req,
  input  logic [REQ_DATA_WIDTH-1:0] client0_data_req,
  output logic                      client0_ack,
  output logic [ACK_DATA_WIDTH-1:0] client0_data_ack,
  input  logic                      client1_req,
  input  logic [REQ_DATA_WIDTH-1:0] client1_data_req,
  output logic                      client1_ack,
  output logic [ACK_DATA_WIDTH-1:0] client1_data_ack,
  output logic                      server_req,
  output logic [REQ_DATA_WIDTH-1:0] server_data_req,
  input  logic                      server_ack,
  input  logic [ACK_DATA_WIDTH-1:0] server_data_ack,
  output logic                      grant_id,
  output logic                      referee_timeout
);

  typedef enum logic [1:0] {IDLE, SERVE, RESP} state_t;

  // A zero-width counter is illegal, so the disabled-timeout build keeps one saturating bit.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic                      last_served;
  logic                      grant_nxt;
  logic                      timeout_hit;
  logic                      server_req_nxt;
  logic [REQ_DATA_WIDTH-1:0] server_data_nxt;
  logic                      ack0_nxt, ack1_nxt, timeout_nxt;
  logic [ACK_DATA_WIDTH-1:0] data0_nxt, data1_nxt, rsp_data;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LIMIT);

  // State and registered outputs.
  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      last_served      <= 1'b1;
      grant_id         <= 1'b0;
      server_req       <= 1'b0;
      server_data_req  <= '0;
      client0_ack      <= 1'b0;
      client0_data_ack <= '0;
      client1_ack      <= 1'b0;
      client1_data_ack <= '0;
      referee_timeout  <= 1'b0;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      if (state == RESP) last_served <= grant_id;
      grant_id         <= grant_nxt;
      server_req       <= server_req_nxt;
      server_data_req  <= server_data_nxt;
      client0_ack      <= ack0_nxt;
      client0_data_ack <= data0_nxt;
      client1_ack      <= ack1_nxt;
      client1_data_ack <= data1_nxt;
      referee_timeout  <= timeout_nxt;
    end
  end

  // Next state, arbitration and timeout counter.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    cnt_nxt   = '0;
    unique case (state)
      IDLE: begin
        if (client0_req && client1_req) begin
          grant_nxt = ~last_served;
          state_nxt = SERVE;
        end else if (client0_req) begin
          grant_nxt = 1'b0;
          state_nxt = SERVE;
        end else if (client1_req) begin
          grant_nxt = 1'b1;
          state_nxt = SERVE;
        end
      end
      SERVE: begin
        if (server_ack || timeout_hit) state_nxt = RESP;
        else cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; server_ack wins over a coincident timeout.
  always_comb begin
    server_req_nxt  = 1'b0;
    server_data_nxt = server_data_req;
    ack0_nxt        = 1'b0;
    ack1_nxt        = 1'b0;
    data0_nxt       = '0;
    data1_nxt       = '0;
    timeout_nxt     = 1'b0;
    rsp_data        = server_ack ? server_data_ack : {ACK_DATA_WIDTH{1'b1}};
    unique case (state)
      IDLE: begin
        if (state_nxt == SERVE) begin
          server_req_nxt  = 1'b1;
          server_data_nxt = grant_nxt ? client1_data_req : client0_data_req;
        end
      end
      SERVE: begin
        if (state_nxt == RESP) begin
          timeout_nxt = !server_ack;
          if (grant_id) begin
            ack1_nxt  = 1'b1;
            data1_nxt = rsp_data;
          end else begin
            ack0_nxt  = 1'b1;
            data0_nxt = rsp_data;
          end
        end else begin
          server_req_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
